// File: rtl/sgf_mult_round_norm.sv
// Post-multiplier significand normalizer and IEEE-754 rounder.
// Two-stage valid/ready pipeline: stage 1 normalizes the 2*SW product, stage 2 rounds it.
module sgf_mult_round_norm #(
    parameter int SW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2*SW-1:0] sgf_product_i,
    input  logic            sign_i,
    input  logic [1:0]      round_mode_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [SW-1:0]   sgf_round_o,
    output logic [1:0]      exp_adj_o,
    output logic            inexact_o,
    output logic            zero_o
);

    localparam logic [1:0] RM_NEAREST = 2'b00;
    localparam logic [1:0] RM_ZERO    = 2'b01;
    localparam logic [1:0] RM_POS     = 2'b10;

    // Round-increment decision for the selected mode.
    function automatic logic round_up(input logic [1:0] mode, input logic guard,
                                      input logic sticky, input logic lsb,
                                      input logic sign);
        logic up;
        case (mode)
            RM_NEAREST: up = guard & (sticky | lsb);
            RM_ZERO:    up = 1'b0;
            RM_POS:     up = (guard | sticky) & ~sign;
            default:    up = (guard | sticky) & sign;
        endcase
        return up;
    endfunction

    // Returns {exp_adj, significand}; a carry out of the increment renormalizes to 1.0.
    function automatic logic [SW+1:0] round_norm(input logic [SW-1:0] norm, input logic up,
                                                 input logic adj);
        logic [SW:0]   sum;
        logic [SW+1:0] res;
        sum = {1'b0, norm} + (SW+1)'(up);
        if (sum[SW])
            res = {({1'b0, adj} + 2'd1), sum[SW:1]};
        else
            res = {{1'b0, adj}, sum[SW-1:0]};
        return res;
    endfunction

    logic            vld_p1, vld_p2;
    logic            adv1, adv2;
    logic [SW-1:0]   norm_p0, norm_p1;
    logic            guard_p0, guard_p1;
    logic            sticky_p0, sticky_p1;
    logic            adj_p0, adj_p1;
    logic            zero_p0, zero_p1;
    logic            sign_p1;
    logic [1:0]      mode_p1;
    logic            up_p1;
    logic [SW+1:0]   res_p1;
    logic [SW-1:0]   round_p2;
    logic [1:0]      exp_adj_p2;
    logic            inexact_p2, zero_p2;

    assign adv2    = ~vld_p2 | ready_i;
    assign adv1    = ~vld_p1 | adv2;
    assign ready_o = adv1;

    // Stage 0 -> 1: normalize so the hidden bit lands at the MSB
    always_comb begin
        if (sgf_product_i[2*SW-1]) begin
            norm_p0   = sgf_product_i[2*SW-1:SW];
            guard_p0  = sgf_product_i[SW-1];
            sticky_p0 = |sgf_product_i[SW-2:0];
            adj_p0    = 1'b1;
        end else begin
            norm_p0   = sgf_product_i[2*SW-2:SW-1];
            guard_p0  = sgf_product_i[SW-2];
            sticky_p0 = |sgf_product_i[SW-3:0];
            adj_p0    = 1'b0;
        end
        zero_p0 = (sgf_product_i == '0);
    end

    always_ff @(posedge clk) begin
        if (adv1 && valid_i) begin
            norm_p1   <= norm_p0;
            guard_p1  <= guard_p0;
            sticky_p1 <= sticky_p0;
            adj_p1    <= adj_p0;
            zero_p1   <= zero_p0;
            sign_p1   <= sign_i;
            mode_p1   <= round_mode_i;
        end
    end

    // Stage 1 -> 2: round and register the outputs
    assign up_p1  = round_up(mode_p1, guard_p1, sticky_p1, norm_p1[0], sign_p1);
    assign res_p1 = round_norm(norm_p1, up_p1, adj_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            round_p2   <= '0;
            exp_adj_p2 <= '0;
            inexact_p2 <= 1'b0;
            zero_p2    <= 1'b0;
        end else begin
            if (adv1)
                vld_p1 <= valid_i;
            if (adv2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    // A zero product forces every other field to zero.
                    round_p2   <= zero_p1 ? '0 : res_p1[SW-1:0];
                    exp_adj_p2 <= zero_p1 ? 2'd0 : res_p1[SW+1:SW];
                    inexact_p2 <= ~zero_p1 & (guard_p1 | sticky_p1);
                    zero_p2    <= zero_p1;
                end
            end
        end
    end

    assign valid_o     = vld_p2;
    assign sgf_round_o = round_p2;
    assign exp_adj_o   = exp_adj_p2;
    assign inexact_o   = inexact_p2;
    assign zero_o      = zero_p2;

endmodule

// File: tb/tb_sgf_mult_round_norm.sv
// Directed self-checking bench for sgf_mult_round_norm (SW=24).
// Result fields are compared packed as {zero, inexact, exp_adj, sgf_round}.
module tb_sgf_mult_round_norm;

    localparam int SW = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_i;
    logic            ready_o;
    logic [2*SW-1:0] sgf_product_i;
    logic            sign_i;
    logic [1:0]      round_mode_i;
    logic            valid_o;
    logic            ready_i;
    logic [SW-1:0]   sgf_round_o;
    logic [1:0]      exp_adj_o;
    logic            inexact_o;
    logic            zero_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [27:0] cap_q[$];

    sgf_mult_round_norm #(.SW(SW)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .sgf_product_i(sgf_product_i), .sign_i(sign_i), .round_mode_i(round_mode_i),
        .valid_o(valid_o), .ready_i(ready_i), .sgf_round_o(sgf_round_o),
        .exp_adj_o(exp_adj_o), .inexact_o(inexact_o), .zero_o(zero_o)
    );

    always #5 clk = ~clk;

    // Record every output transfer in arrival order.
    always @(posedge clk)
        if (!rst && valid_o && ready_i)
            cap_q.push_back({zero_o, inexact_o, exp_adj_o, sgf_round_o});

    function automatic logic [27:0] outs();
        return {zero_o, inexact_o, exp_adj_o, sgf_round_o};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2*SW-1:0] p, input logic s,
                         input logic [1:0] m);
        valid_i       = v;
        sgf_product_i = p;
        sign_i        = s;
        round_mode_i  = m;
    endtask

    // One isolated transaction with the output side always ready.
    task automatic run_one(input string tag, input logic [2*SW-1:0] p, input logic s,
                           input logic [1:0] m, input logic [27:0] exp);
        drive(1'b1, p, s, m);
        ready_i = 1'b1;
        #1;
        chk({tag, ".ready"}, ready_o, 1);
        step();
        drive(1'b0, '0, 1'b0, 2'b00);
        #1;
        chk({tag, ".lat1"}, valid_o, 0);
        step();
        chk({tag, ".lat2"}, valid_o, 1);
        chk({tag, ".data"}, outs(), exp);
        step();
    endtask

    logic [27:0] snap;
    logic [27:0] exp4 [4];
    int          base;

    initial begin
        rst = 1'b1;
        ready_i = 1'b1;
        drive(1'b0, '0, 1'b0, 2'b00);
        step();
        step();
        chk("reset.valid", valid_o, 0);
        chk("reset.outs", outs(), 0);
        chk("reset.ready", ready_o, 1);
        rst = 1'b0;
        step();

        run_one("rne_1x1",     48'h400000000000, 1'b0, 2'b00, {1'b0, 1'b0, 2'd0, 24'h800000});
        run_one("rne_15x15",   48'h900000000000, 1'b0, 2'b00, {1'b0, 1'b0, 2'd1, 24'h900000});
        run_one("rne_carry",   48'h7FFFFFC00000, 1'b0, 2'b00, {1'b0, 1'b1, 2'd1, 24'h800000});
        run_one("tie_even",    48'h400000400000, 1'b0, 2'b00, {1'b0, 1'b1, 2'd0, 24'h800000});
        run_one("tie_odd",     48'h400000C00000, 1'b0, 2'b00, {1'b0, 1'b1, 2'd0, 24'h800002});
        run_one("rtz",         48'h400000C00000, 1'b0, 2'b01, {1'b0, 1'b1, 2'd0, 24'h800001});
        run_one("rpos_s0",     48'h400000800001, 1'b0, 2'b10, {1'b0, 1'b1, 2'd0, 24'h800002});
        run_one("rpos_s1",     48'h400000800001, 1'b1, 2'b10, {1'b0, 1'b1, 2'd0, 24'h800001});
        run_one("rneg_s1",     48'h400000800001, 1'b1, 2'b11, {1'b0, 1'b1, 2'd0, 24'h800002});
        run_one("rneg_s0",     48'h400000800001, 1'b0, 2'b11, {1'b0, 1'b1, 2'd0, 24'h800001});
        run_one("rne_sticky",  48'h400000800001, 1'b0, 2'b00, {1'b0, 1'b1, 2'd0, 24'h800001});
        run_one("zero",        48'h000000000000, 1'b0, 2'b10, {1'b1, 1'b0, 2'd0, 24'h000000});

        // Backpressure: four products, downstream stalls for three cycles.
        exp4[0] = {1'b0, 1'b0, 2'd0, 24'h800000};
        exp4[1] = {1'b0, 1'b0, 2'd1, 24'h900000};
        exp4[2] = {1'b0, 1'b1, 2'd1, 24'h800000};
        exp4[3] = {1'b0, 1'b1, 2'd0, 24'h800002};
        cap_q.delete();
        drive(1'b1, 48'h400000000000, 1'b0, 2'b00);
        step();
        drive(1'b1, 48'h900000000000, 1'b0, 2'b00);
        step();
        drive(1'b1, 48'h7FFFFFC00000, 1'b0, 2'b00);
        ready_i = 1'b0;
        #1;
        chk("bp.ready_full", ready_o, 0);
        chk("bp.valid_full", valid_o, 1);
        snap = outs();
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bp.ready_hold", ready_o, 0);
            chk("bp.stable", outs(), snap);
        end
        step();
        ready_i = 1'b1;
        #1;
        chk("bp.ready_resume", ready_o, 1);
        step();
        drive(1'b1, 48'h400000C00000, 1'b0, 2'b00);
        step();
        drive(1'b0, '0, 1'b0, 2'b00);
        for (int i = 0; i < 20 && cap_q.size() < 4; i++)
            step();
        chk("bp.count", cap_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bp.res%0d", i), (i < cap_q.size()) ? cap_q[i] : 28'hFFFFFFF, exp4[i]);
        step();
        step();
        chk("bp.no_extra", cap_q.size(), 4);

        // Reset with both stages full and the output stalled.
        ready_i = 1'b0;
        drive(1'b1, 48'h7FFFFFC00000, 1'b0, 2'b00);
        step();
        drive(1'b1, 48'h400000C00000, 1'b1, 2'b10);
        step();
        drive(1'b0, '0, 1'b0, 2'b00);
        #1;
        chk("mrst.pre_valid", valid_o, 1);
        chk("mrst.pre_ready", ready_o, 0);
        base = cap_q.size();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mrst.valid", valid_o, 0);
        chk("mrst.outs", outs(), 0);
        chk("mrst.ready", ready_o, 1);
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mrst.no_stale", valid_o, 0);
        end
        chk("mrst.no_capture", cap_q.size(), base);

        run_one("post_rst", 48'h900000000000, 1'b0, 2'b00, {1'b0, 1'b0, 2'd1, 24'h900000});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
